// File: rtl/delay_timer_rw.sv
// Programmable delay timer with cycle prescaler and one-shot, periodic and free-run modes.
// Config (mode, terminal count, prescale) is captured on start and held for the whole run.
module delay_timer_rw #(
  parameter int WIDTH      = 14,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      delay_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      q_delay,
  output logic                  busy,
  output logic                  done,
  output logic                  tick,
  output logic                  wrap
);

  // state | meaning
  // IDLE  | not timing; q_delay holds last value for readout
  // RUN   | counting prescaled ticks toward the latched terminal count
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_FREERUN  = 2'b10;

  state_t                  state;
  logic [1:0]              mode_l;
  logic [WIDTH-1:0]        n_l;
  logic [PRESCALE_W-1:0]   p_l;
  logic [PRESCALE_W-1:0]   pre_cnt;

  always_ff @(posedge clk) begin
    done <= 1'b0;
    tick <= 1'b0;
    wrap <= 1'b0;
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      q_delay <= '0;
      pre_cnt <= '0;
      mode_l  <= '0;
      n_l     <= '0;
      p_l     <= '0;
    end else if (abort) begin
      state   <= IDLE;
      busy    <= 1'b0;
      pre_cnt <= '0;
    end else if (start) begin
      state   <= RUN;
      busy    <= 1'b1;
      mode_l  <= mode;
      n_l     <= delay_val;
      p_l     <= prescale;
      q_delay <= '0;
      pre_cnt <= '0;
    end else if (state == RUN) begin
      if (pre_cnt == p_l) begin
        pre_cnt <= '0;
        tick    <= 1'b1;
        case (mode_l)
          MODE_FREERUN: begin
            q_delay <= q_delay + WIDTH'(1);
            if (&q_delay) wrap <= 1'b1;
          end
          MODE_PERIODIC: begin
            if (q_delay == n_l) begin
              done    <= 1'b1;
              q_delay <= '0;
            end else begin
              q_delay <= q_delay + WIDTH'(1);
            end
          end
          default: begin
            // one-shot (reserved 11 included): stop with q_delay parked at N
            if (q_delay == n_l) begin
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              q_delay <= q_delay + WIDTH'(1);
            end
          end
        endcase
      end else begin
        pre_cnt <= pre_cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_delay_timer_rw.sv
// Bench for delay_timer_rw: directed scenarios plus random traffic, all checked each
// cycle against a model that derives outputs from elapsed cycles since start.
module tb_delay_timer_rw;
  localparam int WIDTH = 14;
  localparam int PW    = 8;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [1:0]       mode;
  logic [WIDTH-1:0] delay_val;
  logic [PW-1:0]    prescale;
  logic [WIDTH-1:0] q_delay;
  logic             busy, done, tick, wrap;

  delay_timer_rw #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .delay_val(delay_val), .prescale(prescale), .q_delay(q_delay),
    .busy(busy), .done(done), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // model: a run is "c cycles since start"; ticks land every P+1 cycles, t = ticks so far
  bit     m_run = 0;
  longint m_c;
  int     m_mode, m_n, m_p;
  longint e_q = 0;
  bit     e_busy = 0, e_done = 0, e_tick = 0, e_wrap = 0;

  task automatic model(input bit r, input bit s, input bit a, input int md, input int n, input int p);
    longint t;
    e_done = 0; e_tick = 0; e_wrap = 0;
    if (r) begin
      m_run = 0; e_q = 0;
    end else if (a) begin
      m_run = 0;
    end else if (s) begin
      m_run = 1; m_c = 0; m_mode = md; m_n = n; m_p = p; e_q = 0;
    end else if (m_run) begin
      m_c++;
      if (m_c % (m_p + 1) == 0) begin
        t = m_c / (m_p + 1);
        e_tick = 1;
        if (m_mode == 2) begin
          e_q    = t % (longint'(1) << WIDTH);
          e_wrap = (e_q == 0);
        end else if (m_mode == 1) begin
          e_q    = t % (m_n + 1);
          e_done = (e_q == 0);
        end else if (t == m_n + 1) begin
          e_done = 1; m_run = 0;
        end else begin
          e_q = t;
        end
      end
    end
    e_busy = m_run;
  endtask

  task automatic cyc(input bit r, input bit s, input bit a, input int md, input int n, input int p);
    rst = r; start = s; abort = a;
    mode = 2'(md); delay_val = WIDTH'(n); prescale = PW'(p);
    @(posedge clk);
    model(r, s, a, md, n, p);
    @(negedge clk);
    chk("q_delay", q_delay, e_q);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("tick", tick, e_tick);
    chk("wrap", wrap, e_wrap);
  endtask

  // idle cycles with junk config to show it is ignored outside start
  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      cyc(0, 0, 0, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7));
  endtask

  int wraps, dones;

  initial begin
    rst = 1; start = 0; abort = 0; mode = 0; delay_val = 0; prescale = 0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("reset_q", q_delay, 0);
    chk("reset_busy", busy, 0);

    // reset mid-run, periodic N=5
    cyc(0, 1, 0, 1, 5, 0);
    idle(8);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_midrun_q", q_delay, 0);
    idle(5);

    // one-shot N=3 P=0: done 4 cycles after start, q parked at 3
    cyc(0, 1, 0, 0, 3, 0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (done) dones++;
    end
    chk("oneshot_done_cnt", dones, 1);
    idle(3);
    chk("oneshot_hold_q", q_delay, 3);
    chk("oneshot_busy", busy, 0);

    // prescaled periodic N=2 P=4: done at 15, 30, 45
    cyc(0, 1, 0, 1, 2, 4);
    dones = 0;
    for (int i = 1; i <= 46; i++) begin
      idle(1);
      if (done) begin
        dones++;
        chk("periodic_done_cycle", i, 15 * dones);
      end
    end
    chk("periodic_done_cnt", dones, 3);

    // free-run wrap at 16383 -> 0
    cyc(0, 1, 0, 2, 0, 0);
    wraps = 0; dones = 0;
    for (int i = 0; i < 16390; i++) begin
      idle(1);
      if (wrap) begin
        wraps++;
        chk("wrap_q", q_delay, 0);
      end
      if (done) dones++;
    end
    chk("freerun_wraps", wraps, 1);
    chk("freerun_dones", dones, 0);

    // abort at q=2, one-shot N=10
    cyc(0, 1, 0, 0, 10, 0);
    idle(2);
    cyc(0, 0, 1, 0, 0, 0);
    idle(3);
    chk("abort_hold_q", q_delay, 2);

    // restart during periodic run at q=3 with N=1
    cyc(0, 1, 0, 1, 4, 0);
    idle(3);
    cyc(0, 1, 0, 1, 1, 0);
    idle(4);

    // abort and start together: abort wins
    cyc(0, 1, 0, 1, 3, 0);
    idle(2);
    cyc(0, 1, 1, 0, 7, 0);
    idle(3);
    chk("collide_busy", busy, 0);

    // start coincident with one-shot terminal match (N=1 P=0)
    cyc(0, 1, 0, 0, 1, 0);
    idle(1);
    cyc(0, 1, 0, 0, 2, 1);
    chk("start_suppress_done", done, 0);
    idle(8);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 59) == 0), $urandom_range(0, 3),
          $urandom_range(0, 6), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/delay_timer_rw.md
Name: delay_timer_rw

Overview:
Parametrised programmable delay timer, the successor to the fixed 14-bit free-running delay counter used for sensor read/write spacing in the health-monitor datapath. It adds a cycle prescaler, a latched terminal value, and one-shot, periodic and free-run modes. It has a start/abort control interface and reports busy, done, tick and wrap. Sensor interface FSMs use it to time conversion waits and sample intervals.

Parameters:
WIDTH, 14, width of delay counter q_delay and delay_val
PRESCALE_W, 8, width of prescale input and internal prescale counter

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  1-cycle request; latch config and (re)start timing
abort  in  1  stop timing, return to IDLE
mode  in  2  00 one-shot, 01 periodic, 10 free-run, 11 reserved (behaves as one-shot)
delay_val  in  WIDTH  terminal count N
prescale  in  PRESCALE_W  tick divisor P; a tick occurs every P+1 clk cycles
q_delay  out  WIDTH  current delay count
busy  out  1  high while in RUN
done  out  1  1-cycle pulse at terminal count
tick  out  1  1-cycle pulse on each prescaled tick
wrap  out  1  1-cycle pulse when the free-run count wraps from all-ones to 0

Behaviour:
- Reset: state IDLE; q_delay, internal prescale counter pre_cnt, and latched mode_l/N_l/P_l all 0; busy, done, tick, wrap all 0. rst overrides all inputs, including mid-RUN.
- States: IDLE and RUN. busy = (state==RUN), registered with the state.
- Priority each cycle: rst > abort > start > counting.
- abort: go to IDLE on the next edge. q_delay holds its value for readout. No done or wrap. Prescaler cleared.
- start, in any state: latch mode, delay_val and prescale. Set q_delay=0, pre_cnt=0, state=RUN. A start while in RUN restarts the timer.
- Config inputs are ignored outside a start cycle. Changing them during RUN has no effect.
- Prescaler, RUN only: the internal tick condition is pre_cnt==P_l. On tick, pre_cnt becomes 0; otherwise pre_cnt increments. The tick output is that condition, registered (1-cycle pulse). With P=0 a tick occurs every cycle.
- On each tick in RUN:
  - One-shot (00/11): if q_delay==N_l, done=1 for one cycle and state becomes IDLE, with q_delay holding N_l. Otherwise q_delay increments.
  - Periodic (01): if q_delay==N_l, done=1 for one cycle and q_delay becomes 0; state stays RUN. Otherwise q_delay increments.
  - Free-run (10): q_delay increments modulo 2^WIDTH, never asserts done. wrap=1 for one cycle when q_delay goes from all-ones to 0.
- Latency: start sampled at edge 0 → first done visible (N+1)*(P+1) cycles later.
  - Example: N=0, P=0 gives done 1 cycle after start.
  - Periodic mode: subsequent done pulses every (N+1)*(P+1) cycles.
- A start or abort in the same cycle as a terminal match suppresses that done pulse.
- In IDLE: no tick, done or wrap; q_delay holds.
- With mode 10 and P=0, behaviour matches the legacy free-running counter: +1 per cycle, 14-bit wrap.

Test Plan:
- Reset: rst high mid-RUN (mode 01, N=5) → next cycle q_delay=0, busy=0, done=0, tick=0. No activity until the next start.
- One-shot: start, mode 00, N=3, P=0 → busy high; q_delay steps 0,1,2,3; done pulses exactly 4 cycles after start; then busy=0 with q_delay held at 3.
- Prescaled periodic: mode 01, N=2, P=4 → tick every 5 cycles; done at cycles 15, 30 and 45 after start; q_delay returns to 0 after each done.
- Free-run wrap: WIDTH=14, mode 10, P=0 → q_delay reaches 16383, then 0; wrap pulses once on that cycle; done never asserts.
- Abort/restart:
  - Abort at q_delay=2 (one-shot, N=10) → IDLE, q_delay stays 2, no done.
  - Start during RUN (periodic, N=4, q_delay=3) with new N=1 → q_delay=0 next cycle; done 2 cycles later.
- Collision: abort and start asserted together → IDLE, no restart. Start coincident with a terminal match → no done that cycle; timer restarts.
